// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types, funct3 encodings and lane helpers for lsu_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } err_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // funct3[1:0] encodes the access size for every legal load and store
  function automatic logic [3:0] size_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   size_be = 4'b0001 << off;
      2'b01:   size_be = off[1] ? 4'b1100 : 4'b0011;
      default: size_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   store_lanes = {4{data[7:0]}};
      2'b01:   store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Selects the addressed byte/half of a read word and extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata_i[7:0];
    case (addr_i)
      2'd0:    w_byte = rdata_i[7:0];
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      default: w_byte = rdata_i[31:24];
    endcase
  end

  assign w_half = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      LB:      data_o = {{24{w_byte[7]}}, w_byte};
      LH:      data_o = {{16{w_half[15]}}, w_half};
      LBU:     data_o = {24'd0, w_byte};
      LHU:     data_o = {16'd0, w_half};
      default: data_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : RV32I load/store unit with req/gnt/rvalid data-memory handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] load_data_o,
  output logic [1:0]  err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam bit               TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_store;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic              r_done;
  logic [31:0]       r_load;
  err_e              r_err;
  logic              r_req;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;

  logic              w_illegal;
  logic              w_misalign;
  logic              w_timeout;
  logic [31:0]       w_load;

  always_comb begin
    w_illegal = 1'b1;
    if (is_store_i) begin
      case (funct3_i)
        SB, SH, SW: w_illegal = 1'b0;
        default:    w_illegal = 1'b1;
      endcase
    end else begin
      case (funct3_i)
        LB, LH, LW, LBU, LHU: w_illegal = 1'b0;
        default:              w_illegal = 1'b1;
      endcase
    end
  end

  assign w_misalign = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                      ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));

  // The counter spans REQ and WAIT_R together, so the abort bound covers the whole access
  assign w_timeout = TO_EN && (r_cnt >= TO_LAST);

  lsu_load_align u_align (
    .rdata_i  (mem_rdata_i),
    .addr_i   (r_off),
    .funct3_i (r_funct3),
    .data_o   (w_load)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_is_store <= 1'b0;
      r_funct3   <= '0;
      r_off      <= '0;
      r_done     <= 1'b0;
      r_load     <= '0;
      r_err      <= ERR_NONE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_is_store <= is_store_i;
            r_funct3   <= funct3_i;
            r_off      <= addr_i[1:0];
            r_we       <= is_store_i;
            r_addr     <= {addr_i[31:2], 2'b00};
            r_be       <= size_be(funct3_i[1:0], addr_i[1:0]);
            r_wdata    <= store_lanes(funct3_i[1:0], wdata_i);
            r_load     <= '0;
            if (w_illegal) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= ERR_ILLEGAL;
            end else if (w_misalign) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= ERR_MISALIGN;
            end else begin
              r_state <= REQ;
              r_req   <= 1'b1;
              r_cnt   <= '0;
              r_err   <= ERR_NONE;
            end
          end
        end
        REQ: begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          if (mem_gnt_i) begin
            r_req <= 1'b0;
            if (r_is_store) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= WAIT_R;
            end
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_state <= DONE;
            r_done  <= 1'b1;
            r_err   <= ERR_TIMEOUT;
          end
        end
        WAIT_R: begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          if (mem_rvalid_i) begin
            r_load  <= w_load;
            r_state <= DONE;
            r_done  <= 1'b1;
          end else if (w_timeout) begin
            r_load  <= '0;
            r_state <= DONE;
            r_done  <= 1'b1;
            r_err   <= ERR_TIMEOUT;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stall_o     = req_valid_i & ~r_done;
  assign done_o      = r_done;
  assign load_data_o = r_load;
  assign err_o       = r_err;
  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_be_o    = r_be;
  assign mem_wdata_o = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Self-checking bench for lsu_ctrl against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, done_o;
  logic [31:0] load_data_o;
  logic [1:0]  err_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int n_checks = 0;
  int n_errors = 0;

  // observations from the last access
  int          o_lat, o_reqc;
  logic [1:0]  o_err;
  logic [31:0] o_data, o_addr, o_wdata;
  logic [3:0]  o_be;
  logic        o_we;
  bit          o_stall_bad, o_unstable;

  always #5 clk_i = ~clk_i;

  lsu_ctrl #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .is_store_i(is_store_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o),
    .done_o(done_o), .load_data_o(load_data_o), .err_o(err_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  // ---------------- reference model ----------------
  function automatic logic [1:0] exp_err(bit st, logic [2:0] f3, logic [31:0] a);
    if (st) begin
      if (f3 > 3'd2) return 2'b11;
    end else if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) begin
      return 2'b11;
    end
    if (f3[1:0] == 2'd1 && a[0]) return 2'b01;
    if (f3[1:0] == 2'd2 && a[1:0] != 2'd0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] exp_be(logic [2:0] f3, logic [31:0] a);
    int nbytes;
    nbytes = 1 << f3[1:0];
    return 4'(((1 << nbytes) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] exp_wdata(logic [2:0] f3, logic [31:0] wd);
    if (f3[1:0] == 2'd0) return {24'd0, wd[7:0]} * 32'h01010101;
    if (f3[1:0] == 2'd1) return {16'd0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
    logic [31:0] s;
    s = rd >> (8 * a[1:0]);
    case (f3)
      3'd0:    return {{24{s[7]}}, s[7:0]};
      3'd1:    return {{16{s[15]}}, s[15:0]};
      3'd4:    return {24'd0, s[7:0]};
      3'd5:    return {16'd0, s[15:0]};
      default: return rd;
    endcase
  endfunction

  function automatic int exp_lat(bit st, logic [1:0] e, int g, int r);
    if (e != 2'b00) return 1;
    return st ? 2 + g : 3 + g + r;
  endfunction

  // ---------------- access driver (memory grants after g req cycles, rvalid r cycles later) ----------------
  task automatic run_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int g, input int r, input logic [31:0] rd);
    int  reqc, gnt_at;
    bit  seen;
    o_lat = -1; o_err = 2'b00; o_data = '0; o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0;
    o_stall_bad = 1'b0; o_unstable = 1'b0; seen = 1'b0; reqc = 0; gnt_at = -1;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    req_valid_i = 1'b1; is_store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd;
    #1;
    if (stall_o !== 1'b1) o_stall_bad = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk_i); #1;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
      if (done_o === 1'b1) begin
        if (stall_o !== 1'b0) o_stall_bad = 1'b1;
        o_lat = c; o_err = err_o; o_data = load_data_o;
        break;
      end
      if (stall_o !== 1'b1) o_stall_bad = 1'b1;
      if (mem_req_o === 1'b1) begin
        if (!seen) begin
          seen = 1'b1; o_addr = mem_addr_o; o_be = mem_be_o; o_wdata = mem_wdata_o; o_we = mem_we_o;
        end else if ({mem_addr_o, mem_be_o, mem_wdata_o, mem_we_o} !== {o_addr, o_be, o_wdata, o_we}) begin
          o_unstable = 1'b1;
        end
        if (reqc == g) begin
          mem_gnt_i = 1'b1; gnt_at = c;
        end
        reqc++;
      end else if (gnt_at >= 0 && !st && (c - gnt_at - 1) == r) begin
        mem_rvalid_i = 1'b1; mem_rdata_i = rd;
      end
    end
    o_reqc = reqc;
    req_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0; req_valid_i = 1'b0; is_store_i = 1'b0; funct3_i = '0; addr_i = '0; wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if ({done_o, load_data_o, err_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, stall_o} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got done=%b ld=%h err=%b req=%b we=%b addr=%h be=%b wd=%h stall=%b, expected all 0",
               done_o, load_data_o, err_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, stall_o);
    end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_loads();
    run_access(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
    n_checks++; if (o_lat !== 3) begin n_errors++; $display("FAIL lw_latency: got %0d expected 3", o_lat); end
    n_checks++; if (o_data !== 32'hDEADBEEF || o_err !== 2'b00) begin n_errors++; $display("FAIL lw_data: got %h err %b expected deadbeef err 00", o_data, o_err); end
    n_checks++; if (o_addr !== 32'h100 || o_be !== 4'b1111 || o_we !== 1'b0) begin n_errors++; $display("FAIL lw_bus: got addr %h be %b we %b expected 100 1111 0", o_addr, o_be, o_we); end
    n_checks++; if (o_stall_bad) begin n_errors++; $display("FAIL lw_stall: got bad stall pattern expected high T..T+2 low at done"); end
    run_access(1'b0, 3'b000, 32'h203, 32'h0, 0, 0, 32'h80FF7F01);
    n_checks++; if (o_data !== 32'hFFFFFF80 || o_be !== 4'b1000) begin n_errors++; $display("FAIL lb_sext: got %h be %b expected ffffff80 1000", o_data, o_be); end
    run_access(1'b0, 3'b100, 32'h203, 32'h0, 0, 0, 32'h80FF7F01);
    n_checks++; if (o_data !== 32'h00000080) begin n_errors++; $display("FAIL lbu_zext: got %h expected 00000080", o_data); end
    run_access(1'b0, 3'b001, 32'h2, 32'h0, 1, 2, 32'h8001_7FFE);
    n_checks++; if (o_data !== 32'hFFFF8001 || o_lat !== 6) begin n_errors++; $display("FAIL lh_upper: got %h lat %0d expected ffff8001 lat 6", o_data, o_lat); end
  endtask

  task automatic test_store_delayed_gnt();
    run_access(1'b1, 3'b001, 32'h42, 32'h1234ABCD, 3, 0, 32'h0);
    n_checks++; if (o_reqc !== 4) begin n_errors++; $display("FAIL sh_req_cycles: got %0d expected 4", o_reqc); end
    n_checks++; if (o_be !== 4'b1100 || o_wdata !== 32'hABCDABCD || o_addr !== 32'h40 || o_we !== 1'b1) begin
      n_errors++; $display("FAIL sh_bus: got be %b wd %h addr %h we %b expected 1100 abcdabcd 40 1", o_be, o_wdata, o_addr, o_we); end
    n_checks++; if (o_unstable) begin n_errors++; $display("FAIL sh_hold: got bus change while waiting for grant expected stable"); end
    n_checks++; if (o_lat !== 5 || o_err !== 2'b00) begin n_errors++; $display("FAIL sh_latency: got %0d err %b expected 5 err 00", o_lat, o_err); end
  endtask

  task automatic test_errors();
    run_access(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0);
    n_checks++; if (o_lat !== 1 || o_err !== 2'b01 || o_reqc !== 0) begin
      n_errors++; $display("FAIL lw_misalign: got lat %0d err %b req %0d expected 1 01 0", o_lat, o_err, o_reqc); end
    run_access(1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0);
    n_checks++; if (o_lat !== 1 || o_err !== 2'b11 || o_reqc !== 0) begin
      n_errors++; $display("FAIL ld_illegal: got lat %0d err %b req %0d expected 1 11 0", o_lat, o_err, o_reqc); end
    run_access(1'b1, 3'b100, 32'h100, 32'h0, 0, 0, 32'h0);
    n_checks++; if (o_err !== 2'b11 || o_reqc !== 0) begin n_errors++; $display("FAIL st_illegal: got err %b req %0d expected 11 0", o_err, o_reqc); end
  endtask

  task automatic test_timeout();
    bit late_bad;
    run_access(1'b1, 3'b010, 32'h80, 32'h5, 1000, 0, 32'h0);
    n_checks++; if (o_reqc !== TO || o_lat !== TO + 1 || o_err !== 2'b10) begin
      n_errors++; $display("FAIL to_req: got req %0d lat %0d err %b expected %0d %0d 10", o_reqc, o_lat, o_err, TO, TO + 1); end
    run_access(1'b0, 3'b010, 32'h84, 32'h0, 0, 1000, 32'h0);
    n_checks++; if (o_lat !== TO + 1 || o_err !== 2'b10 || o_data !== 32'h0) begin
      n_errors++; $display("FAIL to_wait: got lat %0d err %b data %h expected %0d 10 0", o_lat, o_err, o_data, TO + 1); end
    late_bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
      @(posedge clk_i); #1;
      if (done_o !== 1'b0 || mem_req_o !== 1'b0) late_bad = 1'b1;
    end
    mem_rvalid_i = 1'b0;
    n_checks++; if (late_bad) begin n_errors++; $display("FAIL late_rvalid: got done/req activity expected none"); end
    run_access(1'b1, 3'b000, 32'h91, 32'hA5, TO - 1, 0, 32'h0);
    n_checks++; if (o_reqc !== TO || o_lat !== TO + 1 || o_err !== 2'b00) begin
      n_errors++; $display("FAIL gnt_wins: got req %0d lat %0d err %b expected %0d %0d 00", o_reqc, o_lat, o_err, TO, TO + 1); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 3'b010, 32'h200, 32'h11223344, 0, 0, 32'h0);
    run_access(1'b0, 3'b101, 32'h206, 32'h0, 0, 0, 32'h9876_5432);
    n_checks++; if (o_lat !== 3 || o_data !== 32'h00009876) begin
      n_errors++; $display("FAIL b2b: got lat %0d data %h expected 3 00009876", o_lat, o_data); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      bit          st;
      logic [2:0]  f3;
      logic [31:0] a, wd, rd;
      logic [1:0]  e;
      int          g, r;
      st = 1'($urandom); f3 = 3'($urandom_range(0, 7)); a = $urandom; wd = $urandom; rd = $urandom;
      g = $urandom_range(0, 4); r = $urandom_range(0, 3);
      e = exp_err(st, f3, a);
      run_access(st, f3, a, wd, g, r, rd);
      n_checks++; if (o_err !== e || o_lat !== exp_lat(st, e, g, r)) begin
        n_errors++; $display("FAIL rnd_resp[%0d]: got err %b lat %0d expected %b %0d", i, o_err, o_lat, e, exp_lat(st, e, g, r)); end
      n_checks++; if (o_reqc !== ((e == 2'b00) ? g + 1 : 0) || o_stall_bad || o_unstable) begin
        n_errors++; $display("FAIL rnd_req[%0d]: got req %0d stall_bad %b unstable %b expected %0d 0 0", i, o_reqc, o_stall_bad, o_unstable, (e == 2'b00) ? g + 1 : 0); end
      if (e == 2'b00) begin
        n_checks++;
        if (o_addr !== {a[31:2], 2'b00} || o_be !== exp_be(f3, a) || o_we !== st ||
            (st && o_wdata !== exp_wdata(f3, wd))) begin
          n_errors++; $display("FAIL rnd_bus[%0d]: got addr %h be %b we %b wd %h expected %h %b %b %h",
                               i, o_addr, o_be, o_we, o_wdata, {a[31:2], 2'b00}, exp_be(f3, a), st, exp_wdata(f3, wd));
        end
        if (!st) begin
          n_checks++; if (o_data !== exp_load(f3, a, rd)) begin
            n_errors++; $display("FAIL rnd_load[%0d]: got %h expected %h", i, o_data, exp_load(f3, a, rd)); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    req_valid_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h300;
    @(posedge clk_i); #1;
    n_checks++; if (mem_req_o !== 1'b1) begin n_errors++; $display("FAIL rst_pre_req: got %b expected 1", mem_req_o); end
    #2 rst_ni = 1'b0;
    #1;
    n_checks++; if (mem_req_o !== 1'b0 || done_o !== 1'b0 || err_o !== 2'b00) begin
      n_errors++; $display("FAIL rst_in_req: got req %b done %b err %b expected 0 0 00", mem_req_o, done_o, err_o); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    n_checks++; if (mem_req_o !== 1'b0 || done_o !== 1'b0 || err_o !== 2'b00 || load_data_o !== '0) begin
      n_errors++; $display("FAIL rst_in_wait: got req %b done %b err %b ld %h expected 0 0 00 0", mem_req_o, done_o, err_o, load_data_o); end
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    run_access(1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 0, 0, 32'h0);
    n_checks++; if (o_lat !== 2 || o_err !== 2'b00 || o_addr !== 32'h10 || o_be !== 4'b1111 || o_wdata !== 32'hCAFEF00D) begin
      n_errors++; $display("FAIL post_rst_sw: got lat %0d err %b addr %h be %b wd %h expected 2 00 10 1111 cafef00d",
                           o_lat, o_err, o_addr, o_be, o_wdata); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store_delayed_gnt();
    test_errors();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit directly downstream of the ALU: takes the ALU result (alu_data_o) as the effective address for RV32I loads and stores.
- Generates byte-enables and lane-replicated store data.
- Runs a request/grant/response handshake with data memory, then aligns and sign/zero-extends load data for writeback.
- Stalls the single-cycle core while an access is outstanding; reports misaligned, illegal and timed-out accesses.

Parameters:
TIMEOUT, 16, max cycles spent in REQ+WAIT_R before abort; 0 disables timeout
CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset (one clock; asynchronous, active-low)
req_valid_i  in  1  current instruction is a load or store
is_store_i  in  1  1 = store, 0 = load; sampled with req_valid_i
funct3_i  in  3  RV32I funct3 of the memory instruction
addr_i  in  32  effective address from ALU
wdata_i  in  32  store data (rs2)
stall_o  out  1  hold PC/pipeline; = req_valid_i & ~done_o (combinational)
done_o  out  1  one-cycle pulse: access finished (ok or error)
load_data_o  out  32  aligned/extended load result; valid while done_o
err_o  out  2  error code; valid while done_o
mem_req_o  out  1  memory request
mem_we_o  out  1  write enable
mem_addr_o  out  32  word address {addr[31:2],2'b00}
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  lane-replicated store data
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  32  read data word

Behaviour:
- Reset: state IDLE, counter 0. All registered outputs 0: done_o, load_data_o, err_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o.
- Reset mid-access: mem_req_o drops asynchronously and the transaction is abandoned.
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE, req_valid_i=1: capture is_store, funct3, addr[1:0], the word address and formatted wdata/be.
  - Illegal funct3 (load 011/110/111; store 1xx/011) -> DONE, err=ILLEGAL, no memory access.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) -> DONE, err=MISALIGN, no memory access.
  - Otherwise -> REQ, counter cleared.
- REQ: mem_req_o=1; mem_addr/be/wdata/we held stable until grant.
  - mem_gnt_i: store -> DONE (err=NONE); load -> WAIT_R.
  - Counter reaches TIMEOUT first -> DONE, err=TIMEOUT.
- WAIT_R: mem_req_o=0.
  - mem_rvalid_i -> register extracted data -> DONE.
  - Timeout -> DONE, err=TIMEOUT, load_data_o=0.
- DONE: done_o=1 for exactly one cycle, stall_o=0, then unconditional -> IDLE. A back-to-back request is accepted on the following IDLE cycle.
- Grant and timeout in the same cycle: grant wins.
- mem_rvalid_i is ignored outside WAIT_R. System rule: memory never responds to an aborted request.
- Counter: increments each cycle in REQ/WAIT_R; cleared on entry to REQ; saturates.
- Store formatting:
  - SB: be=4'b0001<<addr[1:0], wdata={4{wdata_i[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{wdata_i[15:0]}}.
  - SW: be=4'b1111, wdata=wdata_i.
- Load extraction:
  - byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Loads drive be per size, same as stores.
- Latency with zero-wait memory (gnt in the REQ cycle, rvalid the next cycle), from the accept cycle T:
  - Store: done_o at T+2.
  - Load: done_o at T+3.
  - Misaligned/illegal: done_o at T+1.

Decomposition:
- Package lsu_pkg:
  - state enum {IDLE,REQ,WAIT_R,DONE}.
  - funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW.
  - err enum {NONE=2'b00, MISALIGN=2'b01, TIMEOUT=2'b10, ILLEGAL=2'b11}.
- Sub-module lsu_load_align (combinational): inputs rdata, addr[1:0], funct3; output 32-bit extended result.

Test Plan:
- LW addr=0x100, rdata=0xDEADBEEF, gnt immediate, rvalid next cycle -> mem_addr=0x100, be=1111; done_o at T+3; load_data=0xDEADBEEF, err=00; stall_o high T..T+2.
- LB addr=0x203, rdata=0x80FF7F01 -> be=1000, load_data=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH addr=0x42, wdata=0x1234ABCD, gnt delayed 3 cycles -> mem_req_o high 4 cycles with be=1100, wdata=0xABCDABCD; done_o 1 cycle after grant.
- LW addr=0x101 -> no mem_req_o; done_o at T+1; err=01. Load funct3=011 -> err=11.
- TIMEOUT=16, gnt never asserted -> mem_req_o high 16 cycles then low; done_o with err=10. A late rvalid afterwards is ignored.
- rst_ni low while in WAIT_R -> mem_req_o/done_o/err_o immediately 0. After release, a fresh SW to 0x10 completes normally.
